// File: rtl/sc_pkg.sv
// Shared types and Sobol helpers for the stochastic number generators.
package sc_pkg;

  localparam int SC_WIDTH = 14;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sng_state_e;

  // Direction vector v_k for a 1-D Sobol sequence of the given dimension.
  function automatic logic [31:0] dir_vec(input int dim, input int width, input int k);
    logic [31:0] v;
    if (dim == 0) begin
      v = 32'd1 << (width - 1 - k);
    end else begin
      v = 32'd1 << (width - 1);
      for (int j = 1; j <= k; j++) v = v ^ (v >> 1);
    end
    return v;
  endfunction

  function automatic int lowest_zero_index(input logic [31:0] idx);
    int r;
    r = 32;
    for (int i = 31; i >= 0; i--) begin
      if (!idx[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/sobol_seq_gen.sv
// Sobol point generator: Gray-code ordered, one new point per advance.
// Latency: x/idx update on the edge where advance or clear is high; clear wins.
module sobol_seq_gen
  import sc_pkg::*;
#(
  parameter int WIDTH = SC_WIDTH,
  parameter int DIM   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] idx
);

  if (DIM != 0 && DIM != 1) begin : g_bad_dim
    $error("sobol_seq_gen: DIM must be 0 or 1");
  end
  if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
    $error("sobol_seq_gen: WIDTH must be 1..31");
  end

  logic [WIDTH-1:0] v_tab [WIDTH];

  for (genvar k = 0; k < WIDTH; k++) begin : g_dir
    localparam logic [31:0] VK = dir_vec(DIM, WIDTH, k);
    assign v_tab[k] = VK[WIDTH-1:0];
  end

  int               lz;
  logic [WIDTH-1:0] step;

  // Gray-code order: moving idx -> idx+1 flips exactly the bit at idx's lowest zero.
  always_comb begin
    lz   = lowest_zero_index(32'(idx));
    step = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (lz == k) step = v_tab[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x   <= '0;
      idx <= '0;
    end else if (clear) begin
      x   <= '0;
      idx <= '0;
    end else if (advance) begin
      x   <= x ^ step;
      idx <= idx + WIDTH'(1);
    end
  end

endmodule

// File: rtl/sobol_sng.sv
// Binary-to-stochastic encoder: emits 2^WIDTH unipolar bits whose ones count equals in_value.
// Latency: first bit one cycle after accept; out_bit/out_last hold while out_ready is low.
module sobol_sng
  import sc_pkg::*;
#(
  parameter int WIDTH = SC_WIDTH,
  parameter int DIM   = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WIDTH:0] in_value,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_bit,
  output logic           out_last,
  output logic [WIDTH:0] ones_count
);

  localparam logic [WIDTH:0]   N_VAL    = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH-1:0] LAST_IDX = '1;

  sng_state_e       state, state_nxt;
  logic [WIDTH:0]   val;
  logic [WIDTH-1:0] x, idx;
  logic             is_last, accept, xfer, clear, advance;

  sobol_seq_gen #(
    .WIDTH (WIDTH),
    .DIM   (DIM)
  ) u_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .advance (advance),
    .x       (x),
    .idx     (idx)
  );

  assign is_last  = (idx == LAST_IDX);
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;
  assign clear    = accept || (xfer && is_last);
  assign advance  = xfer && !is_last;
  assign out_bit  = (state == RUN) && ({1'b0, x} < val);
  assign out_last = (state == RUN) && is_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        out_valid = 1'b1;
        if (out_ready && is_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Values above 2^WIDTH saturate so the comparator never sees an unreachable probability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val        <= '0;
      ones_count <= '0;
    end else if (accept) begin
      val        <= (in_value > N_VAL) ? N_VAL : in_value;
      ones_count <= '0;
    end else if (xfer) begin
      ones_count <= ones_count + (WIDTH+1)'(out_bit);
    end
  end

endmodule

// File: tb/tb_sobol_sng.sv
// Randomized self-checking bench for sobol_sng against a closed-form Sobol model.
module tb_sobol_sng;

  localparam int W  = 14;
  localparam int N  = 1 << W;
  localparam int WS = 4;
  localparam int NS = 1 << WS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            b_in_valid  = 1'b0;
  logic            b_out_ready = 1'b0;
  logic [W:0]      b_in_value  = '0;
  logic [1:0]      b_in_ready, b_out_valid, b_out_bit, b_out_last;
  logic [1:0][W:0] b_ones;

  logic             s_in_valid  = 1'b0;
  logic             s_out_ready = 1'b0;
  logic [WS:0]      s_in_value  = '0;
  logic [1:0]       s_in_ready, s_out_valid, s_out_bit, s_out_last;
  logic [1:0][WS:0] s_ones;

  sobol_sng #(.WIDTH(W), .DIM(0)) dut_b0 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready[0]),
    .in_value(b_in_value), .out_valid(b_out_valid[0]), .out_ready(b_out_ready),
    .out_bit(b_out_bit[0]), .out_last(b_out_last[0]), .ones_count(b_ones[0]));
  sobol_sng #(.WIDTH(W), .DIM(1)) dut_b1 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready[1]),
    .in_value(b_in_value), .out_valid(b_out_valid[1]), .out_ready(b_out_ready),
    .out_bit(b_out_bit[1]), .out_last(b_out_last[1]), .ones_count(b_ones[1]));
  sobol_sng #(.WIDTH(WS), .DIM(0)) dut_s0 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready[0]),
    .in_value(s_in_value), .out_valid(s_out_valid[0]), .out_ready(s_out_ready),
    .out_bit(s_out_bit[0]), .out_last(s_out_last[0]), .ones_count(s_ones[0]));
  sobol_sng #(.WIDTH(WS), .DIM(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready[1]),
    .in_value(s_in_value), .out_valid(s_out_valid[1]), .out_ready(s_out_ready),
    .out_bit(s_out_bit[1]), .out_last(s_out_last[1]), .ones_count(s_ones[1]));

  int checks   = 0;
  int failures = 0;
  int xb [2][N];
  int xs [2][NS];

  // Sobol point i in closed form: XOR of direction vectors selected by gray(i).
  function automatic int dvec(input int dim, input int w, input int k);
    int v;
    if (dim == 0) return 1 << (w - 1 - k);
    v = 1 << (w - 1);
    for (int j = 1; j <= k; j++) v = v ^ (v >> 1);
    return v;
  endfunction

  function automatic int sobol_point(input int dim, input int w, input int i);
    int g;
    int x;
    g = i ^ (i >> 1);
    x = 0;
    for (int k = 0; k < w; k++) if (g[k]) x = x ^ dvec(dim, w, k);
    return x;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept_big(input int value, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (b_in_ready == 2'b11) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    b_in_value = (W+1)'(value);
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
  endtask

  // Streams nbits bits through both 14-bit DUTs, tallying deviations from the model.
  task automatic run_big(input int val, input int stall_pct, input bit churn, input int nbits,
                         output int bit_err, output int proto_err, output int cnt_err,
                         output bit timed_out, output logic [3:0] first4);
    int i = 0;
    int budget = 8 * N;
    int exp_ones [2] = '{0, 0};
    bit e;
    bit_err = 0; proto_err = 0; cnt_err = 0; first4 = '0;
    while (i < nbits && budget > 0) begin
      for (int d = 0; d < 2; d++) begin
        e = (xb[d][i] < val);
        if (b_out_bit[d] !== e) bit_err++;
        if (b_out_valid[d] !== 1'b1 || b_in_ready[d] !== 1'b0 || b_out_last[d] !== (i == N - 1))
          proto_err++;
        if (b_ones[d] !== (W+1)'(exp_ones[d])) cnt_err++;
      end
      if (i < 4) first4[i] = b_out_bit[0];
      b_out_ready = ($urandom_range(0, 99) >= stall_pct);
      b_in_valid  = churn;
      if (churn) b_in_value = (i == N - 1) ? 15'd20000 : 15'($urandom_range(0, 32767));
      if (b_out_ready) for (int d = 0; d < 2; d++) exp_ones[d] += int'(xb[d][i] < val);
      tick();
      budget--;
      if (b_out_ready) i++;
    end
    timed_out = (i < nbits);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({b_in_ready[d], b_out_valid[d], b_out_bit[d], b_out_last[d], b_ones[d]} !== {4'b1000, 15'd0}) begin
        failures++;
        $display("FAIL reset_big[%0d]: rdy/vld/bit/last=%b%b%b%b ones=%0d expected 1000 ones=0",
                 d, b_in_ready[d], b_out_valid[d], b_out_bit[d], b_out_last[d], b_ones[d]);
      end
      checks++;
      if ({s_in_ready[d], s_out_valid[d], s_out_bit[d], s_out_last[d], s_ones[d]} !== {4'b1000, 5'd0}) begin
        failures++;
        $display("FAIL reset_small[%0d]: rdy/vld/bit/last=%b%b%b%b ones=%0d expected 1000 ones=0",
                 d, s_in_ready[d], s_out_valid[d], s_out_bit[d], s_out_last[d], s_ones[d]);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  // Half probability with in_valid held and in_value churning during RUN; ends requesting 20000.
  task automatic test_half_stream;
    bit ok, to;
    int be, pe, ce;
    logic [3:0] f4;
    accept_big(8192, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL half_accept: in_ready never high"); end
    run_big(8192, 0, 1'b1, N, be, pe, ce, to, f4);
    checks++;
    if (f4 !== 4'b1001) begin failures++; $display("FAIL half_first4: got %b expected 1001", f4); end
    checks++;
    if (be != 0 || to) begin failures++; $display("FAIL half_bits: %0d bit errors timeout=%0d expected 0", be, to); end
    checks++;
    if (pe != 0) begin failures++; $display("FAIL half_protocol: %0d valid/ready/last errors expected 0", pe); end
    checks++;
    if (ce != 0) begin failures++; $display("FAIL half_running_count: %0d errors expected 0", ce); end
    checks++;
    if (b_in_ready !== 2'b11 || b_out_valid !== 2'b00) begin
      failures++;
      $display("FAIL half_idle_after: in_ready=%b out_valid=%b expected 11/00", b_in_ready, b_out_valid);
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (b_ones[d] !== 15'd8192) begin
        failures++;
        $display("FAIL half_ones[%0d]: got %0d expected 8192", d, b_ones[d]);
      end
    end
  endtask

  // The held request (in_value=20000) starts right after the bubble and saturates to all ones.
  task automatic test_back_to_back_saturate;
    bit to;
    int be, pe, ce;
    logic [3:0] f4;
    tick();
    checks++;
    if (b_out_valid !== 2'b11) begin failures++; $display("FAIL b2b_start: out_valid=%b expected 11", b_out_valid); end
    run_big(N, 0, 1'b0, N, be, pe, ce, to, f4);
    checks++;
    if (be != 0 || pe != 0 || ce != 0 || to) begin
      failures++;
      $display("FAIL sat_stream: bit=%0d proto=%0d cnt=%0d timeout=%0d expected all 0", be, pe, ce, to);
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (b_ones[d] !== 15'd16384) begin
        failures++;
        $display("FAIL sat_ones[%0d]: got %0d expected 16384", d, b_ones[d]);
      end
    end
  endtask

  task automatic test_backpressure;
    bit ok, to;
    int be, pe, ce;
    logic [3:0] f4;
    accept_big(11469, ok);
    run_big(11469, 50, 1'b0, N, be, pe, ce, to, f4);
    checks++;
    if (!ok || be != 0 || to) begin
      failures++;
      $display("FAIL stall_bits: accept=%0d bit errors=%0d timeout=%0d expected 1/0/0", ok, be, to);
    end
    checks++;
    if (pe != 0 || ce != 0) begin failures++; $display("FAIL stall_protocol: proto=%0d cnt=%0d expected 0/0", pe, ce); end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (b_ones[d] !== 15'd11469) begin
        failures++;
        $display("FAIL stall_ones[%0d]: got %0d expected 11469", d, b_ones[d]);
      end
    end
    b_out_ready = 1'b0;
  endtask

  task automatic test_async_reset;
    bit ok, to;
    int be, pe, ce;
    int v;
    logic [3:0] f4;
    v = $urandom_range(1, N - 1);
    accept_big(v, ok);
    run_big(v, 0, 1'b0, 100, be, pe, ce, to, f4);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (b_out_valid !== 2'b00 || b_in_ready !== 2'b11 || b_ones !== '0) begin
      failures++;
      $display("FAIL async_reset: out_valid=%b in_ready=%b ones=%0d/%0d expected 00/11/0",
               b_out_valid, b_in_ready, b_ones[0], b_ones[1]);
    end
    tick();
    #2 rst_n = 1'b1;
    tick();
    accept_big(v, ok);
    run_big(v, 0, 1'b0, 300, be, pe, ce, to, f4);
    checks++;
    if (!ok || be != 0 || pe != 0 || ce != 0 || to) begin
      failures++;
      $display("FAIL restart_stream: accept=%0d bit=%0d proto=%0d cnt=%0d timeout=%0d expected 1/0/0/0/0",
               ok, be, pe, ce, to);
    end
    rst_n = 1'b0;
    b_out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Sweep every value at WIDTH=4; x(i) is recovered as (#values giving bit 0) - 1.
  task automatic test_width4_sweep;
    int zc [2][NS];
    int seen [NS];
    int be [2];
    int i, budget;
    bit ok;
    for (int d = 0; d < 2; d++) begin
      be[d] = 0;
      for (int k = 0; k < NS; k++) zc[d][k] = 0;
    end
    for (int v = 0; v <= NS; v++) begin
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (s_in_ready == 2'b11) begin ok = 1'b1; break; end
        tick();
      end
      s_in_value = (WS+1)'(v);
      s_in_valid = 1'b1;
      tick();
      s_in_valid = 1'b0;
      i = 0;
      budget = 400;
      while (i < NS && budget > 0) begin
        for (int d = 0; d < 2; d++) begin
          if (s_out_valid[d] !== 1'b1 || s_out_bit[d] !== (xs[d][i] < v) || s_out_last[d] !== (i == NS - 1))
            be[d]++;
        end
        s_out_ready = ($urandom_range(0, 99) < 70);
        if (s_out_ready) for (int d = 0; d < 2; d++) zc[d][i] += int'(s_out_bit[d] == 1'b0);
        tick();
        budget--;
        if (s_out_ready) i++;
      end
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (!ok || i < NS || s_ones[d] !== (WS+1)'(v)) begin
          failures++;
          $display("FAIL w4_ones[%0d] v=%0d: got %0d (accept=%0d bits=%0d) expected %0d",
                   d, v, s_ones[d], ok, i, v);
        end
      end
    end
    s_out_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (be[d] != 0) begin failures++; $display("FAIL w4_bits[%0d]: %0d errors expected 0", d, be[d]); end
      for (int k = 0; k < NS; k++) seen[k] = 0;
      ok = 1'b1;
      for (int k = 0; k < NS; k++) begin
        if (zc[d][k] >= 1 && zc[d][k] <= NS) seen[zc[d][k] - 1]++;
        else ok = 1'b0;
      end
      for (int k = 0; k < NS; k++) if (seen[k] != 1) ok = 1'b0;
      checks++;
      if (!ok) begin failures++; $display("FAIL w4_permutation[%0d]: x values not each of 0..15 once", d); end
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) xb[d][i] = sobol_point(d, W, i);
      for (int i = 0; i < NS; i++) xs[d][i] = sobol_point(d, WS, i);
    end
    test_reset();
    test_half_stream();
    test_back_to_back_saturate();
    test_backpressure();
    test_async_reset();
    test_width4_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobol_sng.md
Name: sobol_sng

Overview:
- Sequential stochastic number generator: the binary-to-stochastic encoder whose bitstreams feed the unipolar stochastic arithmetic blocks (AND multiply, etc.) and are decoded downstream by popcount.
- Accepts an unsigned binary probability over a valid/ready handshake.
- Serially emits a 2^WIDTH-bit unipolar bitstream under backpressure.
- Each bit is produced by comparing the latched value against a one-dimensional Sobol sequence generated on the fly with Gray-code updates, so the full-period ones count equals the input value exactly.

Parameters:
- WIDTH, 14, log2 of stream length; N = 2^WIDTH bits per stream (16384 default).
- DIM, 0, Sobol dimension. 0 = van der Corput, v_k = 1<<(WIDTH-1-k). 1 = primitive polynomial x+1, v_0 = 1<<(WIDTH-1), v_k = v_{k-1} ^ (v_{k-1}>>1). Other values are illegal (elaboration error).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request to start a stream.
- in_ready  out  1  high only in IDLE.
- in_value  in  WIDTH+1  probability numerator, p = in_value / 2^WIDTH, legal range 0..2^WIDTH.
- out_valid  out  1  out_bit is valid.
- out_ready  in  1  consumer accepts out_bit.
- out_bit  out  1  current stochastic bit.
- out_last  out  1  marks bit index N-1.
- ones_count  out  WIDTH+1  number of 1s accepted so far in the current/last stream.

Behaviour:
- Reset (async, any time, including mid-stream):
  - state=IDLE, x=0, idx=0, val=0, ones_count=0.
  - in_ready=1, out_valid=0, out_bit=0, out_last=0.
- State machine has two states, IDLE and RUN.
- IDLE:
  - in_ready=1, out_valid=0.
  - in_valid&&in_ready at edge T: latch val=in_value, x=0, idx=0, ones_count=0, state goes to RUN.
  - First out_valid is high in cycle T+1 (1-cycle latency).
- RUN:
  - in_ready=0; in_valid is ignored, with no queueing.
  - out_valid=1.
  - out_bit = (x < val), unsigned compare with x zero-extended to WIDTH+1 bits. out_bit is a pure function of registers, with no combinational path from inputs.
  - out_last = (idx == N-1).
- Bit transfer on out_valid&&out_ready:
  - ones_count += out_bit.
  - If idx<N-1: idx += 1 and x ^= v[c], where c = index of the least-significant zero bit of the old idx.
  - If idx==N-1: state goes to IDLE, and x and idx are cleared.
- With out_ready low, all state holds and out_bit/out_last stay stable (AXI-style stability).
- ones_count holds its final value in IDLE until the next accept.
- Sequence properties:
  - x values over one period form a permutation of 0..N-1, so final ones_count == val exactly for every legal val.
  - in_value > 2^WIDTH is saturated to 2^WIDTH at latch.
- Boundaries:
  - val=0 gives all zeros.
  - val=N gives all ones.
  - idx wrap never occurs, because the stream terminates at N-1.
- Back-to-back streams: in_ready rises the cycle after the last transfer, so there is one IDLE bubble minimum.
- Throughput: 1 bit/cycle with out_ready held high.

Decomposition:
- Shared package sc_pkg holds:
  - default WIDTH constant;
  - state enum {IDLE, RUN};
  - function returning direction vector v_k for (DIM, WIDTH, k);
  - function lowest_zero_index(idx).
- One sub-module, sobol_seq_gen:
  - parameters WIDTH, DIM; ports clk, rst_n, clear, advance;
  - outputs x and idx;
  - holds the direction-vector table and the Gray-code update.
- sobol_sng holds the FSM, handshakes, comparator and ones counter.

Test Plan:
- DIM=0, in_value=8192, out_ready=1 -> first four bits 1,0,0,1 (x=0,8192,12288,4096); out_last on bit 16383 only; ones_count=8192; in_ready=1 next cycle.
- in_value=0 and in_value=16384, both DIMs -> streams all 0 and all 1 respectively; ones_count 0 and 16384.
- DIM=1, in_value=11469, out_ready random 50% -> captured stream identical to the out_ready=1 run; out_bit stable while stalled; ones_count=11469.
- WIDTH=4, both DIMs, sweep in_value 0..16 -> every 16-bit stream has ones_count == in_value; x covers 0..15 exactly once.
- rst_n low asynchronously at bit 100 -> out_valid=0 and in_ready=1 immediately; restart with the same value reproduces the stream from bit 0.
- in_valid held high during RUN, in_value changing -> ignored; new stream starts only after IDLE with the then-current in_value; in_value=20000 saturates (ones_count=16384).
